// File: rtl/rbp_pkg.sv
// Shared encodings for the RBP initiator: command codes, op kinds and FSM states.
package rbp_pkg;

    localparam logic [3:0] RBP_CMD_RSTADDR = 4'd0;
    localparam logic [3:0] RBP_CMD_READ    = 4'd1;
    localparam logic [3:0] RBP_CMD_POSL    = 4'd2;
    localparam logic [3:0] RBP_CMD_POSH    = 4'd3;
    localparam logic [3:0] RBP_CMD_FETCH   = 4'd4;
    localparam logic [3:0] RBP_CMD_START   = 4'd5;
    localparam logic [3:0] RBP_CMD_STOP    = 4'd6;
    localparam logic [3:0] RBP_CMD_TEST    = 4'd15;

    typedef enum logic [1:0] {
        OP_KIND_SINGLE = 2'd0,
        OP_KIND_GETPOS = 2'd1,
        OP_KIND_DUMP   = 2'd2,
        OP_KIND_RSVD   = 2'd3
    } op_kind_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_REQ,
        ST_CAP,
        ST_REL,
        ST_ABORT_RST,
        ST_ABORT_WAIT
    } state_e;

endpackage

// File: rtl/rbp_sync.sv
// Multi-flop synchroniser bringing the responder's asynchronous ack into sys_clk.
module rbp_sync #(
    parameter int STAGES = 2
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb sync_d = {sync_q[STAGES-2:0], d};

    always_ff @(posedge sys_clk) begin
        if (sys_rst) sync_q <= '0;
        else         sync_q <= sync_d;
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/rbp_master.sv
// RBP link initiator: runs SINGLE, GETPOS and DUMP ops as sequences of four-phase
// req/ack transactions with an abort-and-reset path when the responder goes quiet.
//   state      | meaning
//   IDLE       | waiting for an op
//   SETUP      | rbp_cmd driven, settling before req
//   REQ        | rbp_req high, waiting for synchronised ack
//   CAP        | latch rbp_data, drop req
//   REL        | waiting for ack release, then next step or done
//   ABORT_RST  | pulse rbp_rst after a timeout
//   ABORT_WAIT | wait for responder to release ack
module rbp_master
    import rbp_pkg::*;
#(
    parameter int SETUP_CYCLES   = 2,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int RST_CYCLES     = 8
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [1:0]  op_kind,
    input  logic [3:0]  op_cmd,
    input  logic [15:0] op_count,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [15:0] word_data,
    output logic        pos_valid,
    output logic [23:0] pos_data,
    output logic        op_done,
    output logic        op_timeout,
    output logic        busy,
    output logic        rbp_req,
    input  logic        rbp_ack,
    output logic        rbp_rst,
    output logic        rbp_dat,
    output logic [3:0]  rbp_cmd,
    input  logic [15:0] rbp_data
);

    localparam logic [15:0] SETUP_LOAD = 16'(SETUP_CYCLES - 1);
    localparam logic [15:0] TO_LOAD    = 16'(TIMEOUT_CYCLES);
    localparam logic [15:0] RST_LOAD   = 16'(RST_CYCLES - 1);

    state_e      state_q, state_d;
    op_kind_e    kind_q, kind_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] rem_q, rem_d;
    logic        first_q, first_d;
    logic [3:0]  rbp_cmd_q, rbp_cmd_d;
    logic        rbp_req_q, rbp_req_d;
    logic        rbp_rst_q, rbp_rst_d;
    logic        word_valid_q, word_valid_d;
    logic [15:0] word_data_q, word_data_d;
    logic        pos_valid_q, pos_valid_d;
    logic [23:0] pos_data_q, pos_data_d;
    logic        op_done_q, op_done_d;
    logic        op_timeout_q, op_timeout_d;
    logic        ack_s, accept, word_stall, last_step;

    rbp_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .d       (rbp_ack),
        .q       (ack_s)
    );

    assign op_ready   = (state_q == ST_IDLE) && !word_valid_q;
    assign accept     = op_valid && op_ready;
    assign word_stall = word_valid_q && !word_ready;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= ST_IDLE;
            kind_q       <= OP_KIND_SINGLE;
            cnt_q        <= '0;
            rem_q        <= '0;
            first_q      <= 1'b0;
            rbp_cmd_q    <= '0;
            rbp_req_q    <= 1'b0;
            rbp_rst_q    <= 1'b0;
            word_valid_q <= 1'b0;
            word_data_q  <= '0;
            pos_valid_q  <= 1'b0;
            pos_data_q   <= '0;
            op_done_q    <= 1'b0;
            op_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            kind_q       <= kind_d;
            cnt_q        <= cnt_d;
            rem_q        <= rem_d;
            first_q      <= first_d;
            rbp_cmd_q    <= rbp_cmd_d;
            rbp_req_q    <= rbp_req_d;
            rbp_rst_q    <= rbp_rst_d;
            word_valid_q <= word_valid_d;
            word_data_q  <= word_data_d;
            pos_valid_q  <= pos_valid_d;
            pos_data_q   <= pos_data_d;
            op_done_q    <= op_done_d;
            op_timeout_q <= op_timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        first_d   = first_q;
        rbp_cmd_d = rbp_cmd_q;
        last_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    kind_d  = op_kind_e'(op_kind);
                    rem_d   = op_count;
                    first_d = 1'b1;
                    cnt_d   = SETUP_LOAD;
                    case (op_kind_e'(op_kind))
                        OP_KIND_SINGLE: begin state_d = ST_SETUP; rbp_cmd_d = op_cmd;          end
                        OP_KIND_GETPOS: begin state_d = ST_SETUP; rbp_cmd_d = RBP_CMD_POSL;    end
                        OP_KIND_DUMP:   begin state_d = ST_SETUP; rbp_cmd_d = RBP_CMD_RSTADDR; end
                        default:        state_d = ST_IDLE;
                    endcase
                end
            end
            ST_SETUP: begin
                if (cnt_q == 16'd0) begin
                    state_d = ST_REQ;
                    cnt_d   = TO_LOAD;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_REQ: begin
                if (ack_s) begin
                    state_d = ST_CAP;
                end else if (cnt_q == 16'd0) begin
                    state_d = ST_ABORT_RST;
                    cnt_d   = RST_LOAD;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_CAP: begin
                state_d = ST_REL;
                cnt_d   = TO_LOAD;
            end
            ST_REL: begin
                if (!ack_s) begin
                    case (kind_q)
                        OP_KIND_GETPOS: last_step = !first_q;
                        OP_KIND_DUMP:   last_step = first_q ? (rem_q == 16'd0) : (rem_q == 16'd1);
                        default:        last_step = 1'b1;
                    endcase
                    if (last_step) begin
                        state_d = ST_IDLE;
                    end else if (!word_stall) begin
                        // Next transaction only once the previous word has been taken.
                        state_d   = ST_SETUP;
                        cnt_d     = SETUP_LOAD;
                        first_d   = 1'b0;
                        rbp_cmd_d = (kind_q == OP_KIND_GETPOS) ? RBP_CMD_POSH : RBP_CMD_READ;
                        if (kind_q == OP_KIND_DUMP && !first_q) rem_d = rem_q - 16'd1;
                    end
                end else if (cnt_q == 16'd0) begin
                    state_d = ST_ABORT_RST;
                    cnt_d   = RST_LOAD;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_ABORT_RST: begin
                if (cnt_q == 16'd0) state_d = ST_ABORT_WAIT;
                else                cnt_d   = cnt_q - 16'd1;
            end
            ST_ABORT_WAIT: begin
                if (!ack_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rbp_req_d    = (state_d == ST_REQ);
        rbp_rst_d    = (state_d == ST_ABORT_RST);
        word_valid_d = word_valid_q && !word_ready;
        word_data_d  = word_data_q;
        pos_data_d   = pos_data_q;
        pos_valid_d  = 1'b0;
        op_done_d    = 1'b0;
        op_timeout_d = 1'b0;
        if (state_q == ST_CAP) begin
            case (kind_q)
                OP_KIND_GETPOS: begin
                    if (first_q) pos_data_d[15:0]  = rbp_data;
                    else         pos_data_d[23:16] = rbp_data[7:0];
                end
                OP_KIND_DUMP: begin
                    if (!first_q) begin
                        word_valid_d = 1'b1;
                        word_data_d  = rbp_data;
                    end
                end
                default: begin
                    word_valid_d = 1'b1;
                    word_data_d  = rbp_data;
                end
            endcase
        end
        if (state_q == ST_REL && last_step) begin
            op_done_d   = 1'b1;
            pos_valid_d = (kind_q == OP_KIND_GETPOS);
        end
        if (state_q == ST_IDLE && accept && op_kind_e'(op_kind) == OP_KIND_RSVD) op_done_d = 1'b1;
        if (state_d == ST_ABORT_RST && state_q != ST_ABORT_RST) word_valid_d = 1'b0;
        if (state_q == ST_ABORT_WAIT && state_d == ST_IDLE)     op_timeout_d = 1'b1;
    end

    assign rbp_req    = rbp_req_q;
    assign rbp_rst    = rbp_rst_q;
    assign rbp_dat    = 1'b0;
    assign rbp_cmd    = rbp_cmd_q;
    assign word_valid = word_valid_q;
    assign word_data  = word_data_q;
    assign pos_valid  = pos_valid_q;
    assign pos_data   = pos_data_q;
    assign op_done    = op_done_q;
    assign op_timeout = op_timeout_q;
    assign busy       = !op_ready;

endmodule

// File: tb/tb_rbp_master.sv
// Bench for rbp_master: responder BFM, table-driven ops, random ops against an op-level
// model, plus timeout and mid-transaction reset sequences.
module tb_rbp_master;
    import rbp_pkg::*;

    localparam int TO_CYC = 100;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [1:0]  op_kind = 2'd0;
    logic [3:0]  op_cmd = 4'd0;
    logic [15:0] op_count = 16'd0;
    logic        word_valid;
    logic        word_ready = 1'b0;
    logic [15:0] word_data;
    logic        pos_valid;
    logic [23:0] pos_data;
    logic        op_done, op_timeout, busy;
    logic        rbp_req, rbp_rst, rbp_dat;
    logic        bfm_ack = 1'b0;
    logic [3:0]  rbp_cmd;
    logic [15:0] bfm_data = 16'd0;

    always #5 sys_clk = ~sys_clk;

    rbp_master #(
        .SETUP_CYCLES(2), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TO_CYC), .RST_CYCLES(8)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .op_valid(op_valid), .op_ready(op_ready), .op_kind(op_kind), .op_cmd(op_cmd),
        .op_count(op_count), .word_valid(word_valid), .word_ready(word_ready),
        .word_data(word_data), .pos_valid(pos_valid), .pos_data(pos_data),
        .op_done(op_done), .op_timeout(op_timeout), .busy(busy),
        .rbp_req(rbp_req), .rbp_ack(bfm_ack), .rbp_rst(rbp_rst), .rbp_dat(rbp_dat),
        .rbp_cmd(rbp_cmd), .rbp_data(bfm_data)
    );

    int n_checks = 0;
    int n_err    = 0;

    logic [15:0] resp_q[$];
    logic [3:0]  cmd_log[$];
    logic [15:0] got_words[$];
    logic [23:0] got_pos;
    int          pos_cnt, done_cnt, to_cnt;
    int          bfm_delay = 0;
    bit          bfm_mute  = 1'b0;

    logic [3:0]  exp_cmds[$];
    logic [15:0] exp_words[$];
    bit          exp_posv;
    logic [23:0] exp_pos;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Responder: four-phase handshake, answers each request from resp_q.
    initial begin
        forever begin
            @(negedge sys_clk);
            if (!bfm_mute && rbp_req && !bfm_ack) begin
                cmd_log.push_back(rbp_cmd);
                repeat (bfm_delay) @(negedge sys_clk);
                bfm_data = (resp_q.size() > 0) ? resp_q.pop_front() : 16'hDEAD;
                bfm_ack  = 1'b1;
                for (int i = 0; i < 500 && rbp_req; i++) @(negedge sys_clk);
                repeat ($urandom_range(0, 2)) @(negedge sys_clk);
                bfm_ack = 1'b0;
            end
        end
    end

    // Consumer with a 50% ready pattern plus pulse counters.
    initial begin
        forever begin
            @(negedge sys_clk);
            word_ready = 1'($urandom_range(0, 1));
            if (word_valid && word_ready) got_words.push_back(word_data);
            if (pos_valid) begin
                pos_cnt++;
                got_pos = pos_data;
            end
            if (op_done)    done_cnt++;
            if (op_timeout) to_cnt++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Op-level reference: which commands go on the bus and which results come back.
    task automatic model(input logic [1:0] k, input logic [3:0] c, input logic [15:0] n,
                         input logic [15:0] d0, input logic [15:0] d1);
        exp_cmds.delete();
        exp_words.delete();
        exp_posv = 1'b0;
        exp_pos  = 24'd0;
        case (k)
            2'd0: begin
                exp_cmds.push_back(c);
                exp_words.push_back(d0);
            end
            2'd1: begin
                exp_cmds.push_back(4'd2);
                exp_cmds.push_back(4'd3);
                exp_posv = 1'b1;
                exp_pos  = {d1[7:0], d0};
            end
            2'd2: begin
                exp_cmds.push_back(4'd0);
                for (int i = 0; i < int'(n); i++) begin
                    exp_cmds.push_back(4'd1);
                    exp_words.push_back(d1 + 16'(i));
                end
            end
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [1:0] k, input logic [3:0] c, input logic [15:0] n,
                          input logic [15:0] d0, input logic [15:0] d1, input int dly,
                          input string tag);
        int t;
        @(negedge sys_clk);
        resp_q.delete();
        cmd_log.delete();
        got_words.delete();
        pos_cnt = 0; done_cnt = 0; to_cnt = 0; got_pos = 24'd0;
        resp_q.push_back(d0);
        for (int i = 0; i <= int'(n) + 1; i++) resp_q.push_back(d1 + 16'(i));
        bfm_delay = dly;
        model(k, c, n, d0, d1);
        for (int i = 0; i < 1000 && !op_ready; i++) @(negedge sys_clk);
        op_kind = k; op_cmd = c; op_count = n; op_valid = 1'b1;
        @(negedge sys_clk);
        op_valid = 1'b0;
        t = 0;
        while (!((done_cnt + to_cnt) > 0 && op_ready) && t < 3000) begin
            @(negedge sys_clk);
            t++;
        end
        check({tag, " completes"}, 32'(t < 3000), 32'd1);
        repeat (3) @(negedge sys_clk);
        check({tag, " cmd count"}, 32'(cmd_log.size()), 32'(exp_cmds.size()));
        foreach (exp_cmds[i])
            check($sformatf("%s cmd[%0d]", tag, i),
                  (i < cmd_log.size()) ? 32'(cmd_log[i]) : 32'hFFFF_FFFF, 32'(exp_cmds[i]));
        check({tag, " word count"}, 32'(got_words.size()), 32'(exp_words.size()));
        foreach (exp_words[i])
            check($sformatf("%s word[%0d]", tag, i),
                  (i < got_words.size()) ? 32'(got_words[i]) : 32'hFFFF_FFFF, 32'(exp_words[i]));
        check({tag, " pos_valid pulses"}, 32'(pos_cnt), 32'(exp_posv));
        if (exp_posv) check({tag, " pos_data"}, 32'(got_pos), 32'(exp_pos));
        check({tag, " op_done pulses"}, 32'(done_cnt), 32'd1);
        check({tag, " op_timeout pulses"}, 32'(to_cnt), 32'd0);
        check({tag, " op_ready after"}, 32'(op_ready), 32'd1);
    endtask

    typedef struct {
        logic [1:0]  kind;
        logic [3:0]  cmd;
        logic [15:0] count;
        logic [15:0] d0;
        logic [15:0] d1;
        int          dly;
        int          exp_ncmds;
        int          exp_nwords;
        logic [23:0] exp_pos;
        logic [15:0] exp_last_word;
    } vec_t;

    vec_t        vecs[6];
    logic [3:0]  cmd_tab[8];

    initial begin
        int hi, r, t;
        vecs[0] = '{2'd0, 4'd15, 16'd0, 16'h1234, 16'h0000, 5, 1, 1, 24'h000000, 16'h1234};
        vecs[1] = '{2'd1, 4'd0,  16'd0, 16'hBEEF, 16'h0012, 3, 2, 0, 24'h12BEEF, 16'h0000};
        vecs[2] = '{2'd2, 4'd0,  16'd4, 16'h00AA, 16'h0001, 1, 5, 4, 24'h000000, 16'h0004};
        vecs[3] = '{2'd2, 4'd0,  16'd0, 16'h00AA, 16'h0001, 2, 1, 0, 24'h000000, 16'h0000};
        vecs[4] = '{2'd3, 4'd0,  16'd0, 16'h0000, 16'h0000, 0, 0, 0, 24'h000000, 16'h0000};
        vecs[5] = '{2'd0, 4'd5,  16'd0, 16'h5A5A, 16'h0000, 0, 1, 1, 24'h000000, 16'h5A5A};
        cmd_tab = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd15};

        repeat (4) @(negedge sys_clk);
        check("reset outputs zero", 32'(|{rbp_req, rbp_rst, rbp_dat, rbp_cmd, word_valid, word_data,
              pos_valid, pos_data, op_done, op_timeout, busy}), 32'd0);
        check("reset op_ready", 32'(op_ready), 32'd1);
        sys_rst = 1'b0;

        foreach (vecs[v]) begin
            run_op(vecs[v].kind, vecs[v].cmd, vecs[v].count, vecs[v].d0, vecs[v].d1,
                   vecs[v].dly, $sformatf("vec%0d", v));
            check($sformatf("vec%0d table ncmds", v), 32'(cmd_log.size()), 32'(vecs[v].exp_ncmds));
            check($sformatf("vec%0d table nwords", v), 32'(got_words.size()), 32'(vecs[v].exp_nwords));
            if (vecs[v].exp_nwords > 0)
                check($sformatf("vec%0d table last word", v),
                      (got_words.size() > 0) ? 32'(got_words[$]) : 32'hFFFF_FFFF,
                      32'(vecs[v].exp_last_word));
            if (vecs[v].kind == 2'd1)
                check($sformatf("vec%0d table pos", v), 32'(got_pos), 32'(vecs[v].exp_pos));
        end

        for (int i = 0; i < 14; i++)
            run_op(2'($urandom_range(0, 3)), cmd_tab[$urandom_range(0, 7)],
                   16'($urandom_range(0, 6)), 16'($urandom), 16'($urandom),
                   $urandom_range(0, 6), $sformatf("rnd%0d", i));

        // Responder never answers: abort, link reset pulse, timeout pulse.
        @(negedge sys_clk);
        bfm_mute = 1'b1;
        got_words.delete();
        done_cnt = 0; to_cnt = 0;
        op_kind = 2'd0; op_cmd = 4'd4; op_valid = 1'b1;
        @(negedge sys_clk);
        op_valid = 1'b0;
        t = 0;
        while (!rbp_req && t < 50) begin @(negedge sys_clk); t++; end
        check("timeout req rises", 32'(rbp_req), 32'd1);
        hi = 0;
        while (rbp_req && hi < 400) begin @(negedge sys_clk); hi++; end
        check("timeout req high cycles", 32'(hi), 32'd101);
        r = 0;
        while (rbp_rst && r < 50) begin @(negedge sys_clk); r++; end
        check("timeout rbp_rst cycles", 32'(r), 32'd8);
        t = 0;
        while (to_cnt == 0 && t < 50) begin @(negedge sys_clk); t++; end
        repeat (3) @(negedge sys_clk);
        check("timeout pulses", 32'(to_cnt), 32'd1);
        check("timeout no op_done", 32'(done_cnt), 32'd0);
        check("timeout no words", 32'(got_words.size()), 32'd0);
        check("timeout op_ready", 32'(op_ready), 32'd1);

        // Reset while a request is outstanding.
        op_kind = 2'd0; op_cmd = 4'd6; op_valid = 1'b1;
        @(negedge sys_clk);
        op_valid = 1'b0;
        t = 0;
        while (!rbp_req && t < 50) begin @(negedge sys_clk); t++; end
        check("midrst req rises", 32'(rbp_req), 32'd1);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check("midrst outputs zero", 32'(|{rbp_req, rbp_rst, rbp_dat, rbp_cmd, word_valid, word_data,
              pos_valid, pos_data, op_done, op_timeout, busy}), 32'd0);
        check("midrst op_ready", 32'(op_ready), 32'd1);
        sys_rst  = 1'b0;
        bfm_mute = 1'b0;
        run_op(2'd0, 4'd1, 16'd0, 16'h0F0F, 16'h0000, 2, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
